prbs_checker: RTL and testbench

- Serial PRBS receiver/checker. It is the far-end counterpart of the team's parameterised Fibonacci LFSR generator.
- Takes one received bit per valid cycle, self-synchronises a local LFSR to the stream, declares lock, then counts bit errors.
- Sits at the sink end of BER/link-test paths in lab designs.

---
 rtl/prbs_pkg.sv | 13 +
 rtl/prbs_checker_sat_cnt.sv | 19 +
 rtl/prbs_checker.sv | 112 +++++++++++
 tb/tb_prbs_checker.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/prbs_pkg.sv
// prbs_pkg: shared state encoding and default tap masks for the PRBS checker
package prbs_pkg;
    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } state_t;
    localparam logic [6:0]  POLY_7  = 7'b100_0001;
    localparam logic [8:0]  POLY_9  = 9'b0_0010_0001;
    localparam logic [9:0]  POLY_10 = 10'b00_1000_0001;
    localparam logic [14:0] POLY_15 = 15'h4001;
    localparam logic [22:0] POLY_23 = 23'h04_0001;
endpackage

// File: rtl/prbs_checker_sat_cnt.sv
// sat_cnt: saturating up-counter; clear wins over hold, clear plus increment loads 1
module sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt
);
    logic [W-1:0] r_cnt;
    // count up, stick at all-ones, clear to 0 or 1
    always_ff @(posedge clk) begin
        if (rst) r_cnt <= '0;
        else if (i_clr) r_cnt <= {{(W-1){1'b0}}, i_inc};
        else if (i_inc && !(&r_cnt)) r_cnt <= r_cnt + 1'b1;
    end
    assign o_cnt = r_cnt;
endmodule

// File: rtl/prbs_checker.sv
// prbs_checker: serial PRBS receiver that self-synchronises, locks and counts bit errors
// Optional: define PRBS_CHK_SELF_SYNC_EN to keep feeding received bits while locked
import prbs_pkg::*;
module prbs_checker #(
    parameter int               WIDTH     = 10,
    parameter logic [WIDTH-1:0] POLINOM   = 10'b00_1000_0001,
    parameter int               LOCK_THR  = 16,
    parameter int               BAD_THR   = 4,
    parameter int               GOOD_THR  = 8,
    parameter int               ERR_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid_i,
    input  logic                 bit_i,
    input  logic                 clr_i,
    output logic                 lock_o,
    output logic                 err_o,
    output logic [ERR_CNT_W-1:0] err_cnt_o
);
`ifdef PRBS_CHK_SELF_SYNC_EN
    localparam bit SELF_SYNC = 1'b1;
`else
    localparam bit SELF_SYNC = 1'b0;
`endif
    localparam int CMAX = (WIDTH > LOCK_THR) ? ((WIDTH > GOOD_THR) ? WIDTH : GOOD_THR)
                                             : ((LOCK_THR > GOOD_THR) ? LOCK_THR : GOOD_THR);
    localparam int CW = $clog2(CMAX + 1);
    localparam int BW = $clog2(BAD_THR + 1);
    localparam logic [CW-1:0] FILL_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_THR - 1);
    localparam logic [CW-1:0] GOOD_LAST = CW'(GOOD_THR - 1);
    localparam logic [BW-1:0] BAD_LAST  = BW'(BAD_THR - 1);

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_sr, w_sr_nxt;
    logic [CW-1:0]    r_cnt, w_cnt_nxt;
    logic [BW-1:0]    r_bad, w_bad_nxt;
    logic             r_err, w_err_nxt, w_inc, w_pred, w_match, w_in;

    assign w_pred  = ^(r_sr & POLINOM);
    assign w_match = bit_i == w_pred;
    assign w_in    = (r_state == LOCKED && !SELF_SYNC) ? w_pred : bit_i;

    // state, shift register and shared fill/run/good counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= HUNT;
            r_sr    <= '0;
            r_cnt   <= '0;
            r_bad   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_sr    <= w_sr_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bad   <= w_bad_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // next state: fill in HUNT, qualify predictions in CHECK, count errors in LOCKED
    always_comb begin
        w_state_nxt = r_state;
        w_sr_nxt    = r_sr;
        w_cnt_nxt   = r_cnt;
        w_bad_nxt   = r_bad;
        w_err_nxt   = 1'b0;
        w_inc       = 1'b0;
        if (valid_i) begin
            w_sr_nxt = {w_in, r_sr[WIDTH-1:1]};
            case (r_state)
                HUNT: begin
                    w_cnt_nxt   = (r_cnt == FILL_LAST) ? '0 : r_cnt + 1'b1;
                    w_state_nxt = (r_cnt == FILL_LAST) ? CHECK : HUNT;
                end
                CHECK: begin
                    if (!w_match || r_sr == '0) w_cnt_nxt = '0;
                    else if (r_cnt == LOCK_LAST) begin
                        w_cnt_nxt   = '0;
                        w_bad_nxt   = '0;
                        w_state_nxt = LOCKED;
                    end else w_cnt_nxt = r_cnt + 1'b1;
                end
                LOCKED: begin
                    if (!w_match) begin
                        w_err_nxt   = 1'b1;
                        w_inc       = 1'b1;
                        w_cnt_nxt   = '0;
                        w_bad_nxt   = (r_bad == BAD_LAST) ? '0 : r_bad + 1'b1;
                        w_state_nxt = (r_bad == BAD_LAST) ? HUNT : LOCKED;
                    end else begin
                        w_cnt_nxt = (r_cnt == GOOD_LAST) ? '0 : r_cnt + 1'b1;
                        w_bad_nxt = (r_cnt == GOOD_LAST) ? '0 : r_bad;
                    end
                end
                default: w_state_nxt = HUNT;
            endcase
        end
    end

    sat_cnt #(.W(ERR_CNT_W)) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_clr (clr_i),
        .i_inc (w_inc),
        .o_cnt (err_cnt_o)
    );

    assign lock_o = r_state == LOCKED;
    assign err_o  = r_err;
endmodule

// File: tb/tb_prbs_checker.sv
// tb_prbs_checker: directed table-driven bench with a reference generator for prbs_checker
module tb_prbs_checker;
    localparam logic [9:0] POL = 10'b00_1000_0001;

    typedef struct {
        int n;
        int flip;
        bit lock;
        int cnt16;
        int cnt3;
        int pulses;
    } row_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        valid = 1'b0;
    logic        bit_in = 1'b0;
    logic        clr = 1'b0;
    logic        lock16, err16, lock3, err3;
    logic [15:0] cnt16;
    logic [2:0]  cnt3;
    logic [9:0]  g;
    bit          gaps = 1'b0;
    int          checks = 0;
    int          errors = 0;
    int          pulses = 0;
    row_t        tbl[15];

    always #5 clk = ~clk;

    prbs_checker u_dut (
        .clk(clk), .rst(rst), .valid_i(valid), .bit_i(bit_in), .clr_i(clr),
        .lock_o(lock16), .err_o(err16), .err_cnt_o(cnt16)
    );

    prbs_checker #(.ERR_CNT_W(3)) u_dut3 (
        .clk(clk), .rst(rst), .valid_i(valid), .bit_i(bit_in), .clr_i(clr),
        .lock_o(lock3), .err_o(err3), .err_cnt_o(cnt3)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic v, input logic b, input logic c);
        valid  = v;
        bit_in = b;
        clr    = c;
        @(posedge clk);
        #1;
        if (err16 === 1'b1) pulses++;
    endtask

    task automatic send_bit(input bit flip, input logic c);
        if (gaps)
            while ($urandom_range(0, 9) < 3) begin
                step(1'b0, 1'($urandom_range(0, 1)), 1'b0);
                chk("gap_err", {31'd0, err16}, 32'd0);
            end
        step(1'b1, g[0] ^ flip, c);
        g = {^(g & POL), g[9:1]};
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    task automatic run_rows(input int last);
        for (int r = 0; r <= last; r++) begin
            for (int j = 0; j < tbl[r].n; j++) send_bit(j == tbl[r].flip, 1'b0);
            chk($sformatf("row%0d_lock", r), {31'd0, lock16}, {31'd0, tbl[r].lock});
            chk($sformatf("row%0d_cnt", r), {16'd0, cnt16}, tbl[r].cnt16);
            chk($sformatf("row%0d_cnt3", r), {29'd0, cnt3}, tbl[r].cnt3);
            chk($sformatf("row%0d_pulses", r), pulses, tbl[r].pulses);
        end
    endtask

    initial begin
        int base, n_drop;
        bit relock;
        tbl[0] = '{25, -1, 1'b0, 0, 0, 0};
        tbl[1] = '{1, -1, 1'b1, 0, 0, 0};
        tbl[2] = '{474, -1, 1'b1, 0, 0, 0};
        tbl[3] = '{1, 0, 1'b1, 1, 1, 1};
        tbl[4] = '{1499, -1, 1'b1, 1, 1, 1};
        for (int k = 0; k < 10; k++)
            tbl[5+k] = '{9, 0, 1'b1, 2 + k, (2 + k > 7) ? 7 : 2 + k, 2 + k};

        do_reset();
        chk("rst_lock", {31'd0, lock16}, 0);
        chk("rst_err", {31'd0, err16}, 0);
        chk("rst_cnt", {16'd0, cnt16}, 0);
        chk("rst_cnt3", {29'd0, cnt3}, 0);

        g = 10'd1;
        run_rows(14);

        send_bit(1'b1, 1'b1);
        chk("clr_err_cnt", {16'd0, cnt16}, 1);
        chk("clr_err_cnt3", {29'd0, cnt3}, 1);
        send_bit(1'b0, 1'b1);
        chk("clr_cnt", {16'd0, cnt16}, 0);
        chk("clr_cnt3", {29'd0, cnt3}, 0);
        for (int j = 0; j < 8; j++) send_bit(1'b0, 1'b0);

        chk("pre_rst_lock", {31'd0, lock16}, 1);
        send_bit(1'b1, 1'b0);
        do_reset();
        chk("midrst_lock", {31'd0, lock16}, 0);
        chk("midrst_cnt", {16'd0, cnt16}, 0);
        chk("midrst_err", {31'd0, err16}, 0);
        for (int j = 0; j < 25; j++) send_bit(1'b0, 1'b0);
        chk("relock_early", {31'd0, lock16}, 0);
        send_bit(1'b0, 1'b0);
        chk("relock", {31'd0, lock16}, 1);

        do_reset();
        g = 10'd1;
        pulses = 0;
        gaps = 1'b1;
        run_rows(4);
        gaps = 1'b0;

        base = cnt16;
        n_drop = 0;
        while (lock16 && n_drop < 100) begin
            step(1'b1, 1'b0, 1'b0);
            n_drop++;
        end
        chk("drop_lock", {31'd0, lock16}, 0);
        chk("drop_errs_ge4", {31'd0, (cnt16 >= base + 4) ? 1'b1 : 1'b0}, 1);
        base = cnt16;
        relock = 1'b0;
        for (int j = 0; j < 300; j++) begin
            step(1'b1, 1'b0, 1'b0);
            if (lock16) relock = 1'b1;
        end
        chk("zero_no_relock", {31'd0, relock}, 0);
        chk("zero_cnt_frozen", {16'd0, cnt16}, base);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
